// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO between a UART receiver and the SoC,
// with a registered almost_full threshold and a sticky overrun flag for dropped bytes.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int HIGH_WATER = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  almost_full,
  output logic                  overrun,
  input  logic                  overrun_clear
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] HW_CNT = (DEPTH_LOG2 + 1)'(HIGH_WATER);
  logic [7:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [DEPTH_LOG2:0] count_q, count_d;
  logic almost_full_q, almost_full_d, overrun_q, overrun_d;
  logic push, pop, drop;
  assign out_valid = count_q != '0;
  assign out_data = mem_q[rd_q];
  assign count = count_q;
  assign almost_full = almost_full_q;
  assign overrun = overrun_q;
  always_comb begin
    pop = out_valid & out_ready;
    push = in_valid & ((count_q < FULL_CNT) | pop);
    drop = in_valid & ~push;
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    count_d = (push & ~pop) ? count_q + 1'b1 : (pop & ~push) ? count_q - 1'b1 : count_q;
    almost_full_d = count_d >= HW_CNT;
    // a drop in the same cycle as a clear keeps the flag set
    overrun_d = drop | (overrun_q & ~overrun_clear);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      almost_full_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
      almost_full_q <= almost_full_d;
      overrun_q <= overrun_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= in_data;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, log2 of storage depth in bytes (DEPTH = 2**DEPTH_LOG2).
REQ-002 SHALL have parameter HIGH_WATER, default 12, occupancy at or above which almost_full asserts.
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  one-cycle strobe from the serial receiver: new byte present.
REQ-006 SHALL have port in_data  input  8  received byte; valid only while in_valid=1.
REQ-007 SHALL have port out_valid  output  1  FIFO head byte available to the SoC.
REQ-008 SHALL have port out_ready  input  1  SoC accepts head byte when out_valid=1.
REQ-009 SHALL have port out_data  output  8  FIFO head byte.
REQ-010 SHALL have port count  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
REQ-011 SHALL have port almost_full  output  1  count >= HIGH_WATER.
REQ-012 SHALL have port overrun  output  1  sticky: at least one byte was dropped.
REQ-013 SHALL have port overrun_clear  input  1  synchronous clear of overrun.

Function
REQ-014 SHALL store bytes in a circular buffer of DEPTH entries with DEPTH_LOG2-bit read and write pointers that wrap from DEPTH-1 to 0.
REQ-015 SHALL define pop = out_valid & out_ready, and push = in_valid & (count < DEPTH | pop).
REQ-016 SHALL, on push, write in_data at the write pointer and advance it by 1.
REQ-017 SHALL, on pop, advance the read pointer by 1.
REQ-018 SHALL update count by +1 on push only, -1 on pop only, and leave it unchanged on both or neither.
REQ-019 SHALL drive out_valid = (count != 0) and out_data = buffer[read pointer], first-word-fall-through.
REQ-020 SHALL give one cycle of latency: a byte pushed at edge N is visible on out_valid/out_data after edge N, with no earlier combinational path from in_data to out_data.
REQ-021 SHALL, when empty with in_valid=1, push the byte; out_valid stays 0 in that cycle and is 1 the next.
REQ-022 SHALL, when full with in_valid=1 and pop=1 in the same cycle, accept the byte, keep count=DEPTH, and not set overrun.
REQ-023 SHALL, when full with in_valid=1 and pop=0, drop in_data, leave contents and pointers unchanged, and set overrun to 1.
REQ-024 SHALL ignore out_ready while out_valid=0: no pointer or count change.
REQ-025 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-026 SHALL clear overrun on overrun_clear=1; if a drop occurs in the same cycle, the drop wins and overrun remains 1.
REQ-027 SHALL register almost_full from the next-state count so that it changes on the same edge as count.
REQ-028 SHALL preserve byte order exactly: the k-th accepted byte is the k-th popped byte.

Reset
REQ-029 SHALL, while reset=1 and asynchronously, force pointers=0, count=0, out_valid=0, almost_full=0, overrun=0.
REQ-030 SHALL, on reset mid-operation, discard all buffered bytes; storage contents need not be cleared.
REQ-031 SHALL ignore in_valid, out_ready and overrun_clear while reset=1.
REQ-032 SHALL resume normal operation on the first rising edge after reset deasserts.

Verification
REQ-033 SHALL cover single byte: empty, pulse in_valid with 0x41, out_ready=0 -> next cycle out_valid=1, out_data=0x41, count=1; out_ready=1 for one cycle -> count=0, out_valid=0.
REQ-034 SHALL cover fill and overrun: push 0x00..0x0F (16 bytes), then push 0xAA with out_ready=0 -> count=16, overrun=1; drain -> 0x00..0x0F in order, 0xAA never appears.
REQ-035 SHALL cover full with simultaneous push and pop: full, in_valid=1 with 0x55 and out_ready=1 -> count stays 16, overrun=0, and 0x55 is the last byte drained.
REQ-036 SHALL cover wrap-around: 40 bytes streamed with random out_ready stalls and no drops -> output sequence equals input sequence, pointers wrap at least twice.
REQ-037 SHALL cover almost_full hysteresis-free threshold: count 11 -> 12 asserts almost_full on the same edge; pop back to 11 deasserts it.
REQ-038 SHALL cover reset mid-stream: assert reset with count=5 between clock edges -> out_valid=0 and count=0 immediately; overrun_clear racing a drop leaves overrun=1.
